// File: rtl/Pipe_Buf_Reg_PKG.sv
// rtl/Pipe_Buf_Reg_PKG.sv - shared pipeline-buffer types and constants for the fetch stage
package Pipe_Buf_Reg_PKG;

    localparam logic [31:0] PC_RESET  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - keeps the ROM word of an in-flight fetch alive across a stall
module if_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_redirect,
    input  logic        i_stall,
    input  logic        i_fetch,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_instr
);

    logic [31:0] hold_q;
    logic        hold_valid_q;

    // First stall edge latches the word; later stall edges leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q       <= 32'h0;
            hold_valid_q <= 1'b0;
        end else if (i_redirect) begin
            hold_valid_q <= 1'b0;
        end else if (i_stall) begin
            if (i_fetch && !hold_valid_q) begin
                hold_q       <= i_rdata;
                hold_valid_q <= 1'b1;
            end
        end else begin
            hold_valid_q <= 1'b0;
        end
    end

    assign o_instr = hold_valid_q ? hold_q : i_rdata;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register; IF_PERF_CNT_EN adds redirect/stall counters
module if_stage
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    logic [PC_W-1:0] pc_q;
    logic            fetch_q;
    logic [PC_W-1:0] fetch_pc_q;
    if_id_t          r_ifid;
    logic [31:0]     w_instr;
    logic            w_unused_bits;

    if_hold_buf u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .i_redirect (PcSel),
        .i_stall    (stall),
        .i_fetch    (fetch_q),
        .i_rdata    (imem_rdata),
        .o_instr    (w_instr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= PC_RESET[PC_W-1:0];
            fetch_q    <= 1'b0;
            fetch_pc_q <= '0;
            r_ifid     <= '0;
        end else if (PcSel) begin
            pc_q         <= {BrPC[PC_W-1:2], 2'b00};
            fetch_q      <= 1'b0;
            r_ifid.valid <= 1'b0;
        end else if (!stall) begin
            pc_q         <= pc_q + PC_W'(4);
            fetch_q      <= 1'b1;
            fetch_pc_q   <= pc_q;
            r_ifid.valid <= fetch_q;
            // Only a real fetch overwrites pc/instr, so a bubble keeps the last contents.
            if (fetch_q) begin
                r_ifid.pc    <= 32'(fetch_pc_q);
                r_ifid.instr <= w_instr;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_cnt <= 32'h0;
            stall_cnt    <= 32'h0;
        end else if (PcSel) begin
            redirect_cnt <= redirect_cnt + 32'h1;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'h1;
        end
    end
`endif

    assign imem_addr     = pc_q;
    assign id_pc         = r_ifid.pc[PC_W-1:0];
    assign id_instr      = r_ifid.instr;
    assign id_valid      = r_ifid.valid;
    assign w_unused_bits = ^{BrPC, r_ifid.pc};

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning PC and instruction-memory byte-address width.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port stall, input, 1, hazard-unit hold request for PC and IF/ID.
REQ-005 SHALL have port PcSel, input, 1, branch-taken redirect from BranchUnit.
REQ-006 SHALL have port BrPC, input, 32, branch target from BranchUnit.
REQ-007 SHALL have port imem_addr, output, PC_W, byte address to synchronous instruction ROM.
REQ-008 SHALL have port imem_rdata, input, 32, ROM data for the address presented one cycle earlier.
REQ-009 SHALL have ports id_pc (output, PC_W), id_instr (output, 32) and id_valid (output, 1), the registered IF/ID stage contents.

Function
REQ-010 SHALL hold pc_q, in-flight flag fetch_q, in-flight address fetch_pc_q, hold buffer hold_q and hold_valid_q.
REQ-011 SHALL drive imem_addr combinationally from pc_q.
REQ-012 SHALL, on a normal cycle (PcSel=0, stall=0): pc_q <= pc_q+4 modulo 2^PC_W; fetch_q <= 1; fetch_pc_q <= pc_q.
REQ-013 SHALL, on a normal cycle, load id_valid <= fetch_q, id_pc <= fetch_pc_q, and id_instr <= hold_q if hold_valid_q, else imem_rdata; then clear hold_valid_q.
REQ-014 SHALL give a latency of exactly 2 cycles from pc_q=X to id_pc=X with id_valid=1, absent stall or redirect.
REQ-015 SHALL, on a stall cycle (stall=1, PcSel=0), hold pc_q, fetch_q, fetch_pc_q, id_pc, id_instr and id_valid unchanged.
REQ-016 SHALL, on a stall cycle with fetch_q=1 and hold_valid_q=0, capture imem_rdata into hold_q and set hold_valid_q.
REQ-017 SHALL never overwrite hold_q while hold_valid_q=1, however long the stall lasts.
REQ-018 SHALL, on a redirect (PcSel=1): pc_q <= {BrPC[PC_W-1:2],2'b00}; fetch_q, hold_valid_q and id_valid <= 0.
REQ-019 SHALL give redirect priority over a simultaneous stall; the first target instruction appears at id_* exactly 2 cycles after the redirect edge.
REQ-020 SHALL ignore BrPC bits above PC_W-1; BrPC[1:0] SHALL be forced to zero.
REQ-021 SHALL wrap pc_q from 2^PC_W-4 to 0 without any flag.
REQ-022 SHALL leave id_pc and id_instr unchanged whenever id_valid transitions to 0.

Reset
REQ-023 SHALL, while reset=0, immediately and asynchronously clear pc_q, fetch_q, fetch_pc_q, hold_q, hold_valid_q, id_pc, id_instr and id_valid to 0, including mid-stall or mid-redirect.
REQ-024 SHALL fetch address 0 on the first edge after reset release, with id_valid first asserted on the second edge.

Configuration
REQ-025 SHALL, with macro IF_PERF_CNT_EN defined, add outputs redirect_cnt (32) and stall_cnt (32), each cleared by reset.
REQ-026 SHALL increment redirect_cnt on each PcSel=1 cycle and stall_cnt on each stall=1, PcSel=0 cycle, both wrapping at 2^32.
REQ-027 SHALL, without IF_PERF_CNT_EN, omit those ports and their logic with no other behavioural change.

Structure
REQ-028 SHALL take the IF/ID struct typedef (pc, instr, valid), PC_RESET (0) and INSTR_NOP (32'h00000013) from shared package Pipe_Buf_Reg_PKG.
REQ-029 SHALL place the hold buffer (hold_q, hold_valid_q, capture/select logic) in sub-module if_hold_buf.

Verification
REQ-030 SHALL cover: reset release with a ROM holding the word at address A at word A/4 -> id_valid=1 on the 2nd edge with id_pc=0, then id_pc=4 and id_pc=8 on consecutive cycles.
REQ-031 SHALL cover: stall=1 for 3 cycles while id_pc=8 -> id_* frozen; after release id_pc=12 carries the instr@12 captured in the hold buffer, then id_pc=16.
REQ-032 SHALL cover: PcSel=1, BrPC=32'h0000_0040 at pc_q=20 -> id_valid=0 for 2 cycles, then id_pc=64 with instr@64.
REQ-033 SHALL cover: PcSel=1 and stall=1 together, BrPC=32'h0000_0103 -> redirect wins and pc_q=0x100.
REQ-034 SHALL cover: pc_q=508 with PC_W=9 and no stall -> next pc_q=0, and id_pc sequence 508 then 0.
REQ-035 SHALL cover: reset=0 asserted mid-stall with hold_valid_q=1 -> all outputs 0 immediately, and with IF_PERF_CNT_EN both counters 0.
